// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - operand/result handshake bundle for alu_multicycle
interface alu_multicycle_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, aluop, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, aluop, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle MIPS execute ALU, iterative shifter (FAST_SHIFT_EN: barrel shifter)
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic             clk,
    input logic             reset_n,
    alu_multicycle_if.slave bus
);
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [3:0]         op_q,      op_d;
    logic [WIDTH-1:0]   work_q,    work_d;
    logic [SHAMT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               illegal_q, illegal_d;
    logic [SHAMT_W-1:0] amt;

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] v);
        case (op)
            ALU_SLL: shift_one = {v[WIDTH-2:0], 1'b0};
            ALU_SRL: shift_one = {1'b0, v[WIDTH-1:1]};
            default: shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign amt           = bus.a[SHAMT_W-1:0];
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
    assign bus.illegal   = illegal_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d      = bus.aluop;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                    case (bus.aluop)
                        ALU_ADDU: result_d = bus.a + bus.b;
                        ALU_SUBU: result_d = bus.a - bus.b;
                        ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
                        ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
                        ALU_AND:  result_d = bus.a & bus.b;
                        ALU_OR:   result_d = bus.a | bus.b;
                        ALU_XOR:  result_d = bus.a ^ bus.b;
                        ALU_NOR:  result_d = ~(bus.a | bus.b);
                        ALU_LUI:  result_d = {bus.b[15:0], {(WIDTH-16){1'b0}}};
                        ALU_SLL, ALU_SRL, ALU_SRA: begin
`ifdef FAST_SHIFT_EN
                            if (bus.aluop == ALU_SLL)
                                result_d = bus.b << amt;
                            else if (bus.aluop == ALU_SRL)
                                result_d = bus.b >> amt;
                            else
                                result_d = $unsigned($signed(bus.b) >>> amt);
`else
                            if (amt == '0) begin
                                result_d = bus.b;
                            end else begin
                                work_d  = bus.b;
                                cnt_d   = amt;
                                state_d = S_SHIFT;
                            end
`endif
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                // Last shift goes straight into result so DONE lands 1+amount edges after accept.
                work_d = shift_one(op_q, work_q);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    result_d = shift_one(op_q, work_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
module tb_alu_multicycle;
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_XXX  = 4'd15;
`ifdef FAST_SHIFT_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int shift_lat(input int amount);
        return (FAST != 0 || amount == 0) ? 1 : 1 + amount;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_ill,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready_pre"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.aluop    = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.aluop    = op ^ 4'h3;
        bus.a        = ~a;
        bus.b        = ~b;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, bus.result, exp_r);
        chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, exp_r == 32'd0});
        chk({tag, ".illegal"}, {31'b0, bus.illegal}, {31'b0, exp_ill});
        chk({tag, ".in_ready_busy"}, {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_result"}, bus.result, exp_r);
            chk({tag, ".hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
            chk({tag, ".hold_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".in_ready_post"}, {31'b0, bus.in_ready}, 32'd1);
        chk({tag, ".out_valid_post"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.aluop     = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset.result", bus.result, 32'd0);
        chk("reset.zero", {31'b0, bus.zero}, 32'd1);
        chk("reset.illegal", {31'b0, bus.illegal}, 32'd0);
        reset_n = 1'b1;

        run_op("addu_wrap", ALU_ADDU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 0);
        run_op("sra_4", ALU_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, shift_lat(4), 0);
        run_op("srl_4", ALU_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, shift_lat(4), 0);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0);
        run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 0);
        run_op("sll_0", ALU_SLL, 32'h0000_0020, 32'h0000_1234, 32'h0000_1234, 1'b0, 1, 0);
        run_op("sll_31", ALU_SLL, 32'd31, 32'd1, 32'h8000_0000, 1'b0, shift_lat(31), 0);
        run_op("sra_pos", ALU_SRA, 32'd1, 32'h4000_0002, 32'h2000_0001, 1'b0, shift_lat(1), 0);
        run_op("subu", ALU_SUBU, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 3);
        run_op("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 0);
        run_op("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1, 0);
        run_op("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1, 0);
        run_op("nor", ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
        run_op("xxx", ALU_XXX, 32'd7, 32'd9, 32'd0, 1'b1, 1, 0);
        run_op("undef12", 4'd12, 32'd7, 32'd9, 32'd0, 1'b1, 1, 0);
        run_op("lui", ALU_LUI, 32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1, 0);

        // Reset during the fifth SHIFT cycle of a 20-bit SLL.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluop    = ALU_SLL;
        bus.a        = 32'd20;
        bus.b        = 32'd1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("abort.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("abort.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("abort.result", bus.result, 32'd0);
        @(posedge clk);
        #1;
        chk("abort.no_stale", {31'b0, bus.out_valid}, 32'd0);
        run_op("addu_after_abort", ALU_ADDU, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
